fft_frame_ctrl: RTL

//  Sequences the decimator-to-FFT path on fft_clk: frames decimated sin/cos (I/Q) samples into

---
 rtl/fft_ctrl_pkg.sv | 15 +
 rtl/sync_fifo_fwft.sv | 48 ++++
 rtl/fft_frame_ctrl.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/fft_ctrl_pkg.sv
// Shared types and default widths for the decimator-to-FFT framing controller.
package fft_ctrl_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StSettle,
      StStream,
      StDrain
   } state_e;

   localparam int unsigned DefDw       = 24;
   localparam int unsigned DefTw       = 20;
   localparam logic [19:0] DefTuneInit = 20'h2AAAA;

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO with count-based full/empty; push while full is accepted when a
// pop happens on the same edge.
module sync_fifo_fwft #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]    count_q;
   logic             do_push, do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CW'(DEPTH));
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);
   assign rdata_o = mem_q[rd_ptr_q];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q <= count_q + CW'(do_push) - CW'(do_pop);
      end
   end

   // Storage needs no reset: the pointers alone define validity.
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/fft_frame_ctrl.sv
// Frames decimated I/Q samples into fixed-length FFT frames, buffers FFT back-pressure and
// sequences NCO retunes so they land only between frames, followed by a settle discard.
module fft_frame_ctrl
   import fft_ctrl_pkg::*;
#(
   parameter int unsigned   FRAME_LEN  = 1024,
   parameter int unsigned   SETTLE     = 64,
   parameter int unsigned   FIFO_DEPTH = 8,
   parameter int unsigned   DW         = DefDw,
   parameter int unsigned   TW         = DefTw,
   parameter logic [TW-1:0] TUNE_INIT  = TW'(DefTuneInit)
) (
   input  logic          fft_clk,
   input  logic          reset_n,
   input  logic          enable_i,
   input  logic          tune_req_i,
   input  logic [TW-1:0] tune_word_i,
   output logic          tune_ack_o,
   output logic [TW-1:0] sg_tune_o,
   input  logic          in_valid_i,
   input  logic [DW-1:0] in_sin_i,
   input  logic [DW-1:0] in_cos_i,
   input  logic          fft_ready_i,
   output logic          fft_valid_o,
   output logic          fft_sop_o,
   output logic          fft_eop_o,
   output logic [DW-1:0] fft_real_o,
   output logic [DW-1:0] fft_imag_o,
   output logic          overflow_o,
   output logic [15:0]   frame_cnt_o,
   output logic          busy_o
);

   localparam int unsigned FW  = 2 * DW + 2;
   localparam int unsigned IW  = $clog2(FRAME_LEN);
   localparam int unsigned SCW = $clog2(SETTLE + 1);

   state_e           state_q;
   logic             pending_q, tune_ack_q, overflow_q;
   logic [TW-1:0]    pend_word_q, sg_tune_q;
   logic [IW-1:0]    wr_idx_q;
   logic [SCW-1:0]   settle_cnt_q;
   logic [15:0]      frame_cnt_q;

   logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [FW-1:0]    fifo_wdata, fifo_rdata;
   logic             stream_wr, wr_sop, wr_eop, eff_pending, apply;
   logic [TW-1:0]    eff_word;

   always_comb begin
      fifo_pop    = fft_ready_i && !fifo_empty;
      stream_wr   = (state_q == StStream) && in_valid_i;
      fifo_push   = stream_wr && (!fifo_full || fifo_pop);
      wr_sop      = (wr_idx_q == '0);
      wr_eop      = (wr_idx_q == IW'(FRAME_LEN - 1));
      fifo_wdata  = {wr_sop, wr_eop, in_sin_i, in_cos_i};
      // A request arriving on the apply edge supersedes the held word.
      eff_pending = pending_q || tune_req_i;
      eff_word    = tune_req_i ? tune_word_i : pend_word_q;
      apply       = 1'b0;
      case (state_q)
         // When staying idle, let back-to-back requests coalesce into a single retune.
         StIdle:  apply = enable_i ? eff_pending : (pending_q && !tune_req_i);
         StDrain: apply = fifo_empty && eff_pending;
         default: apply = 1'b0;
      endcase
   end

   always_ff @(posedge fft_clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= StIdle;
         pending_q    <= 1'b0;
         pend_word_q  <= '0;
         sg_tune_q    <= TUNE_INIT;
         tune_ack_q   <= 1'b0;
         wr_idx_q     <= '0;
         settle_cnt_q <= '0;
         overflow_q   <= 1'b0;
         frame_cnt_q  <= '0;
      end else begin
         tune_ack_q <= 1'b0;
         if (tune_req_i) begin
            pending_q   <= 1'b1;
            pend_word_q <= tune_word_i;
         end
         if (apply) begin
            pending_q  <= 1'b0;
            sg_tune_q  <= eff_word;
            tune_ack_q <= 1'b1;
         end
         if (fifo_pop && fifo_rdata[FW-2]) frame_cnt_q <= frame_cnt_q + 16'd1;
         if (stream_wr && !fifo_push) overflow_q <= 1'b1;

         case (state_q)
            StIdle: begin
               if (enable_i) begin
                  state_q      <= StSettle;
                  settle_cnt_q <= '0;
               end
            end
            StSettle: begin
               if (!enable_i) begin
                  state_q <= StIdle;
               end else if (in_valid_i) begin
                  if (settle_cnt_q == SCW'(SETTLE - 1)) begin
                     state_q  <= StStream;
                     wr_idx_q <= '0;
                  end else begin
                     settle_cnt_q <= settle_cnt_q + SCW'(1);
                  end
               end
            end
            StStream: begin
               // Dropped samples leave wr_idx alone so every frame stays full length.
               if (fifo_push) begin
                  if (wr_eop) begin
                     wr_idx_q <= '0;
                     if (eff_pending || !enable_i) state_q <= StDrain;
                  end else begin
                     wr_idx_q <= wr_idx_q + IW'(1);
                  end
               end
            end
            StDrain: begin
               if (fifo_empty) begin
                  settle_cnt_q <= '0;
                  state_q      <= (apply && enable_i) ? StSettle : StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   sync_fifo_fwft #(
      .WIDTH(FW),
      .DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk_i  (fft_clk),
      .rst_ni (reset_n),
      .push_i (fifo_push),
      .wdata_i(fifo_wdata),
      .pop_i  (fifo_pop),
      .rdata_o(fifo_rdata),
      .full_o (fifo_full),
      .empty_o(fifo_empty)
   );

   assign fft_valid_o = !fifo_empty;
   assign {fft_sop_o, fft_eop_o, fft_imag_o, fft_real_o} = fifo_empty ? '0 : fifo_rdata;
   assign tune_ack_o  = tune_ack_q;
   assign sg_tune_o   = sg_tune_q;
   assign overflow_o  = overflow_q;
   assign frame_cnt_o = frame_cnt_q;
   assign busy_o      = (state_q != StIdle);

endmodule
